pwm_seno_multicanal: RTL and testbench
======================================

Name: pwm_seno_multicanal

Overview:
- Multi-channel sine-modulated PWM generator; successor to the single-channel fixed-table PWM.
- Shared R-bit carrier counter. Channels are phase-offset by PH table steps (default three-phase, 120°).
- Supports a fixed-duty mode, glitch-free duty updates at period boundaries, enable/freeze, and status ticks.
- Feeds the output driver / LED-motor stage of the project.

Parameters:
R, 6, carrier counter resolution in bits; period = 2^R clk cycles
CH, 3, number of PWM channels (1..8)
PH, 12, per-channel phase offset in table steps; channel k uses index (idx + k*PH) mod 36
NW, 12, width of the N (periods per step) input

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  1 = run; 0 = freeze all counters and outputs
N  in  NW  carrier periods per table step; 0 treated as 1
mode  in  1  0 = sine table; 1 = fixed duty from duty_fix on all channels
duty_fix  in  R  fixed duty used when mode=1
pwm_out  out  CH  PWM outputs, bit k = channel k
step_idx  out  6  current base table index, 0..35
period_tick  out  1  high for the single cycle where the carrier wraps
step_tick  out  1  high for the single cycle where step_idx advances

Behaviour:
- Reset is synchronous and active-high: on a clk edge with rst=1, Q (carrier), n (period count), idx and every duty_reg[k] go to 0. As a result, pwm_out=0, step_idx=0, period_tick=0, step_tick=0 in the cycle after reset. rst has priority over en. Reset mid-period aborts the period immediately.
- Carrier: when en=1, Q <= Q+1 with natural wrap from 2^R-1 to 0. When en=0, Q, n, idx and duty_reg all hold.
- period_tick = en & (Q==2^R-1), combinational from registers.
- Step counter: on a period_tick edge, if n == max(N,1)-1 then n<=0 and idx advances (35 wraps to 0); otherwise n<=n+1.
- step_tick = period_tick & (n == max(N,1)-1).
- Changing N mid-run takes effect at the next comparison. If N is reduced below the current n, the step advances at the next period_tick and n restarts at 0 (n compared with >=, not ==).
- Table: 36 entries, 16-bit unsigned, T[i] = round(65535*(0.5+0.5*sin(2*pi*i/36))). It is a constant ROM, not computed at elaboration.
- Duty scaling: D = (T*2^R) >> 16, truncated, so the maximum value is 2^R-1.
- Duty update: on the period_tick edge, duty_reg[k] loads the value for the new period. In mode 0 this is D of T[(idx_next + k*PH) mod 36], where idx_next is the index after any advance on that same edge. In mode 1 it is duty_fix.
- duty_reg never changes mid-period, so there are no glitches.
- The first period after reset therefore runs with duty 0 (all outputs low for 2^R cycles).
- pwm_out[k] = (Q < duty_reg[k]), comparing registered signals. Duty 0 gives constant low; duty 2^R-1 gives high for all but one cycle per period.
- mode and duty_fix are sampled only at period_tick edges.
- Arithmetic: index modulo uses (idx + k*PH) computed at 9 bits, then a subtract-36 loop bounded by CH. PH must be < 36.

Optional Feature:
- Macro PWM_COMPL_EN. When defined, a parameter DT (default 2) and an output pwm_n_out[CH-1:0] are added.
- pwm_n_out[k] is the complement of pwm_out[k] with dead time: after any edge of pwm_out[k], the newly-asserting output (pwm_out or pwm_n_out) is held low for DT clk cycles.
- During the dead time both outputs are 0; the two are never both 1.
- A per-channel dead-time counter resets to 0 on rst; pwm_n_out resets to 0.
- When PWM_COMPL_EN is undefined, pwm_n_out, DT and the dead-time logic do not exist, and pwm_out behaves exactly as above.

Test Plan:
1. R=6, CH=3, N=2, mode=0. Pulse rst, then run. Required response:
   - pwm_out=000 for the first 64 cycles.
   - Second period: ch0 high 32 cycles; ch1 (idx 12, D=59) high 59 cycles; ch2 (idx 24, D=4) high 4 cycles.
   - period_tick every 64 cycles.
2. Continue test 1. Required response:
   - step_tick on every second period_tick; step_idx=1 after the 2nd period.
   - ch0 duty becomes 37 from the 3rd period.
   - At idx 9, ch0 duty=63; at idx 27, ch0 duty=0.
   - After idx 35, step_idx wraps to 0.
3. N=0. Required response: step_idx advances on every period_tick.
4. mode=1, duty_fix=10, asserted mid-period. Required response: the current period keeps the table duties; from the next period, all channels are high for exactly 10 of 64 cycles.
5. Drop en for 100 cycles mid-period, then rst for 1 cycle mid-operation. Required response:
   - While en=0, pwm_out, Q and step_idx are frozen and no ticks occur.
   - After rst, all state is 0 on the next cycle.
6. With PWM_COMPL_EN, DT=2, mode=1, duty_fix=32. Required response:
   - pwm_n_out rises 2 cycles after pwm_out falls, and pwm_out rises 2 cycles after pwm_n_out falls.
   - pwm_out & pwm_n_out is never 1.

Source files
------------

// File: rtl/pwm_seno_multicanal.sv
// pwm_seno_multicanal: multi-channel sine PWM on a shared carrier; PWM_COMPL_EN adds dead-time complementary outputs
module pwm_seno_multicanal #(
  parameter int R  = 6,
  parameter int CH = 3,
  parameter int PH = 12,
  parameter int NW = 12
`ifdef PWM_COMPL_EN
  ,
  parameter int DT = 2
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [NW-1:0] N,
  input  logic          mode,
  input  logic [R-1:0]  duty_fix,
  output logic [CH-1:0] pwm_out,
`ifdef PWM_COMPL_EN
  output logic [CH-1:0] pwm_n_out,
`endif
  output logic [5:0]    step_idx,
  output logic          period_tick,
  output logic          step_tick
);
  logic [R-1:0]  q_q, q_d;
  logic [NW-1:0] n_q, n_d, n_last;
  logic [5:0]    idx_q, idx_d;
  logic [R-1:0]  duty_q [CH];
  logic [R-1:0]  duty_d [CH];
  logic [CH-1:0] raw;
  logic          last;

  function automatic logic [15:0] sin_tab(input logic [5:0] i);
    case (i)
      6'd0:  return 16'd32768;
      6'd1:  return 16'd38458;
      6'd2:  return 16'd43975;
      6'd3:  return 16'd49151;
      6'd4:  return 16'd53830;
      6'd5:  return 16'd57869;
      6'd6:  return 16'd61145;
      6'd7:  return 16'd63559;
      6'd8:  return 16'd65037;
      6'd9:  return 16'd65535;
      6'd10: return 16'd65037;
      6'd11: return 16'd63559;
      6'd12: return 16'd61145;
      6'd13: return 16'd57869;
      6'd14: return 16'd53830;
      6'd15: return 16'd49151;
      6'd16: return 16'd43975;
      6'd17: return 16'd38458;
      6'd18: return 16'd32768;
      6'd19: return 16'd27077;
      6'd20: return 16'd21560;
      6'd21: return 16'd16384;
      6'd22: return 16'd11705;
      6'd23: return 16'd7666;
      6'd24: return 16'd4390;
      6'd25: return 16'd1976;
      6'd26: return 16'd498;
      6'd27: return 16'd0;
      6'd28: return 16'd498;
      6'd29: return 16'd1976;
      6'd30: return 16'd4390;
      6'd31: return 16'd7666;
      6'd32: return 16'd11705;
      6'd33: return 16'd16384;
      6'd34: return 16'd21560;
      6'd35: return 16'd27077;
      default: return 16'd32768;
    endcase
  endfunction

  // Keep the top R bits of T*2^R/2^16, so full scale maps to 2^R-1
  function automatic logic [R-1:0] scale(input logic [15:0] t);
    logic [15+R:0] p;
    p = {t, {R{1'b0}}};
    return p[15+R:16];
  endfunction

  // Phase-shifted index is below 36*CH, so CH conditional subtractions reduce it mod 36
  function automatic logic [5:0] wrap36(input logic [8:0] s);
    logic [8:0] v;
    v = s;
    for (int j = 0; j < CH; j++) v = (v >= 9'd36) ? v - 9'd36 : v;
    return v[5:0];
  endfunction

  // Carrier, step counter and per-period duty reload
  always_comb begin
    n_last = (N == '0) ? '0 : N - 1'b1;
    last = n_q >= n_last;
    period_tick = en & (&q_q);
    step_tick = period_tick & last;
    q_d = en ? q_q + 1'b1 : q_q;
    n_d = period_tick ? (last ? '0 : n_q + 1'b1) : n_q;
    idx_d = step_tick ? ((idx_q == 6'd35) ? '0 : idx_q + 1'b1) : idx_q;
    for (int k = 0; k < CH; k++) begin
      duty_d[k] = !period_tick ? duty_q[k] : mode ? duty_fix : scale(sin_tab(wrap36(9'(idx_d) + 9'(k * PH))));
      raw[k] = q_q < duty_q[k];
    end
  end

  // State registers; duties only move at the period boundary so pulses never glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
      n_q <= '0;
      idx_q <= '0;
      for (int k = 0; k < CH; k++) duty_q[k] <= '0;
    end else begin
      q_q <= q_d;
      n_q <= n_d;
      idx_q <= idx_d;
      for (int k = 0; k < CH; k++) duty_q[k] <= duty_d[k];
    end
  end

  assign step_idx = idx_q;

`ifdef PWM_COMPL_EN
  logic [CH-1:0] prev_q, chg, quiet;
  logic [7:0]    dt_q [CH];

  // Both sides stay low on the edge cycle plus DT-1 further cycles after every raw transition
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      chg[k] = (DT != 0) && (raw[k] != prev_q[k]);
      quiet[k] = !chg[k] && (dt_q[k] == 8'd0);
      pwm_out[k] = raw[k] & quiet[k];
      pwm_n_out[k] = !raw[k] & quiet[k];
    end
  end

  // Edge history and dead-time countdown; prev starts at 1 so pwm_n_out waits DT after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '1;
      for (int k = 0; k < CH; k++) dt_q[k] <= 8'd0;
    end else if (en) begin
      prev_q <= raw;
      for (int k = 0; k < CH; k++) dt_q[k] <= chg[k] ? 8'(DT - 1) : (dt_q[k] != 8'd0) ? dt_q[k] - 8'd1 : 8'd0;
    end
  end
`else
  assign pwm_out = raw;
`endif
endmodule

// File: tb/tb_pwm_seno_multicanal.sv
// tb_pwm_seno_multicanal: randomized bench against an arithmetic model of the sine PWM
module tb_pwm_seno_multicanal;
  localparam int R  = 6;
  localparam int CH = 3;
  localparam int PH = 12;
  localparam int NW = 12;
  localparam int P  = 1 << R;

  logic          clk;
  logic          rst;
  logic          en;
  logic [NW-1:0] N;
  logic          mode;
  logic [R-1:0]  duty_fix;
  logic [CH-1:0] pwm_out;
  logic [5:0]    step_idx;
  logic          period_tick;
  logic          step_tick;
`ifdef PWM_COMPL_EN
  logic [CH-1:0] pwm_n_out;
`endif

  pwm_seno_multicanal #(.R(R), .CH(CH), .PH(PH), .NW(NW)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .N(N),
    .mode(mode),
    .duty_fix(duty_fix),
    .pwm_out(pwm_out),
`ifdef PWM_COMPL_EN
    .pwm_n_out(pwm_n_out),
`endif
    .step_idx(step_idx),
    .period_tick(period_tick),
    .step_tick(step_tick)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int dtab[36];
  int m_q, m_n, m_idx;
  int m_duty[CH];
  bit armed = 0;
  int hc[CH];

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int nlast();
    return (N == 0) ? 0 : int'(N) - 1;
  endfunction

  // Reference model: counters as plain integers, table index via the % operator
  always @(posedge clk) begin
    if (rst) begin
      m_q = 0;
      m_n = 0;
      m_idx = 0;
      for (int k = 0; k < CH; k++) m_duty[k] = 0;
      armed = 1;
    end else if (en) begin
      if (m_q == P - 1) begin
        if (m_n >= nlast()) begin
          m_n = 0;
          m_idx = (m_idx + 1) % 36;
        end else m_n = m_n + 1;
        for (int k = 0; k < CH; k++) m_duty[k] = mode ? int'(duty_fix) : dtab[(m_idx + k * PH) % 36];
      end
      m_q = (m_q + 1) % P;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("period_tick", int'(period_tick), int'(en && m_q == P - 1));
      chk("step_tick", int'(step_tick), int'(en && m_q == P - 1 && m_n >= nlast()));
      chk("step_idx", int'(step_idx), m_idx);
`ifdef PWM_COMPL_EN
      chk("pwm_excl", int'(|(pwm_out & pwm_n_out)), 0);
`else
      for (int k = 0; k < CH; k++) chk($sformatf("pwm_out[%0d]", k), int'(pwm_out[k]), int'(m_q < m_duty[k]));
`endif
    end
  end

  task automatic count_period();
    hc = '{default: 0};
    for (int c = 0; c < P; c++) begin
      @(negedge clk);
      for (int k = 0; k < CH; k++) hc[k] += int'(pwm_out[k]);
    end
  endtask

  task automatic wait_idx(input int t, input string nm);
    bit ok;
    ok = 0;
    for (int c = 0; c < 6000 && !ok; c++) begin
      @(posedge clk);
      #1;
      ok = (int'(step_idx) == t);
    end
    chk(nm, int'(ok), 1);
  endtask

  initial begin
    int ticks;
    int snap_idx;
    int snap_pwm;
    bit found;
    rst = 1;
    en = 0;
    N = 12'd2;
    mode = 0;
    duty_fix = '0;
    for (int i = 0; i < 36; i++) begin
      int t;
      t = $rtoi($floor(65535.0 * (0.5 + 0.5 * $sin(2.0 * 3.141592653589793 * i / 36.0)) + 0.5));
      dtab[i] = t * P / 65536;
    end
    chk("model_d0", dtab[0], 32);
    chk("model_d1", dtab[1], 37);
    chk("model_d9", dtab[9], 63);
    chk("model_d12", dtab[12], 59);
    chk("model_d24", dtab[24], 4);
    chk("model_d27", dtab[27], 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    en = 1;
    count_period();
    for (int k = 0; k < CH; k++) chk($sformatf("p1_high[%0d]", k), hc[k], 0);
    count_period();
    chk("p2_high[0]", hc[0], 32);
    chk("p2_high[1]", hc[1], 59);
    chk("p2_high[2]", hc[2], 4);
    count_period();
    chk("p3_high[0]", hc[0], 37);
    chk("p3_step_idx", int'(step_idx), 1);
    wait_idx(9, "reach_idx9");
    count_period();
    chk("idx9_high[0]", hc[0], 63);
    wait_idx(27, "reach_idx27");
    count_period();
    chk("idx27_high[0]", hc[0], 0);
    wait_idx(0, "wrap_idx0");
    @(posedge clk);
    #1;
    N = '0;
    ticks = 0;
    for (int c = 0; c < 5 * P; c++) begin
      @(negedge clk);
      ticks += int'(step_tick);
    end
    chk("n0_steps", ticks, 5);
    repeat (P / 2) @(posedge clk);
    #1;
    mode = 1;
    duty_fix = 6'd10;
    found = 0;
    for (int c = 0; c < 2 * P && !found; c++) begin
      @(negedge clk);
      found = period_tick;
    end
    chk("fix_tick_seen", int'(found), 1);
    @(posedge clk);
    #1;
    count_period();
    for (int k = 0; k < CH; k++) chk($sformatf("fix_high[%0d]", k), hc[k], 10);
    repeat (20) @(posedge clk);
    #1;
    en = 0;
    snap_idx = int'(step_idx);
    snap_pwm = int'(pwm_out);
    ticks = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      ticks += int'(period_tick) + int'(step_tick);
    end
    chk("freeze_ticks", ticks, 0);
    chk("freeze_idx", int'(step_idx), snap_idx);
    chk("freeze_pwm", int'(pwm_out), snap_pwm);
    @(posedge clk);
    #1;
    en = 1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("rst_idx", int'(step_idx), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ptick", int'(period_tick), 0);
    mode = 0;
    N = 12'd3;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 699) == 0);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 149) == 0) N = NW'($urandom_range(0, 3));
      if ($urandom_range(0, 249) == 0) mode = ~mode;
      if ($urandom_range(0, 31) == 0) duty_fix = R'($urandom);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
